// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - memOp/memSize encodings, FSM states and alignment helpers
package mem_pkg;

  localparam logic [1:0] MEMOP_NONE = 2'b00;
  localparam logic [1:0] MEMOP_LDS  = 2'b01;
  localparam logic [1:0] MEMOP_LDU  = 2'b10;
  localparam logic [1:0] MEMOP_ST   = 2'b11;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] w_be;
    case (size)
      SZ_B:    w_be = 4'b0001 << off;
      SZ_H:    w_be = off[1] ? 4'b1100 : 4'b0011;
      SZ_W:    w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
    return w_be;
  endfunction

  // memSize 11 has no legal alignment, so it always reports misaligned
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic w_mis;
    case (size)
      SZ_B:    w_mis = 1'b0;
      SZ_H:    w_mis = off[0];
      SZ_W:    w_mis = (off != 2'b00);
      default: w_mis = 1'b1;
    endcase
    return w_mis;
  endfunction

endpackage

// File: rtl/store_lane_gen.sv
// rtl/store_lane_gen.sv - byte enables and lane-replicated store data
module store_lane_gen
  import mem_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_wdata,
  output logic [3:0]  o_we,
  output logic [31:0] o_wdata
);

  always_comb begin
    o_we = byte_en(i_size, i_off);
    case (i_size)
      SZ_B:    o_wdata = {4{i_wdata[7:0]}};
      SZ_H:    o_wdata = {2{i_wdata[15:0]}};
      default: o_wdata = i_wdata;
    endcase
  end

endmodule

// File: rtl/mem_request_unit.sv
// rtl/mem_request_unit.sv - request handshake, alignment check, store lanes and load latency tracking
module mem_request_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W   = 12,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [1:0]        req_memOp,
  input  logic [1:0]        req_memSize,
  input  logic              flush,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       rsp_addr,
  output logic [1:0]        rsp_memOp,
  output logic [1:0]        rsp_memSize,
  output logic [31:0]       rsp_rawDin,
  output logic              rsp_readValid,
  output logic              misalign_fault
);

  localparam logic [1:0] LP_LAT = 2'(READ_LAT);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_cnt;
  logic [31:0] r_rsp_addr;
  logic [1:0]  r_rsp_op;
  logic [1:0]  r_rsp_size;
  logic [31:0] r_rsp_raw;
  logic        r_rsp_valid;
  logic        r_fault;

  logic        w_accept;
  logic        w_is_ld;
  logic        w_is_st;
  logic        w_mis;
  logic        w_ld_go;
  logic        w_st_go;
  logic [3:0]  w_lane_we;

  assign req_ready = (r_state == ST_IDLE) & ~rst;
  assign w_accept  = req_valid & req_ready;
  assign w_is_ld   = (req_memOp == MEMOP_LDS) | (req_memOp == MEMOP_LDU);
  assign w_is_st   = (req_memOp == MEMOP_ST);
  assign w_mis     = (w_is_ld | w_is_st) & is_misaligned(req_memSize, req_addr[1:0]);
  assign w_ld_go   = w_accept & w_is_ld & ~w_mis;
  assign w_st_go   = w_accept & w_is_st & ~w_mis;

  store_lane_gen u_lane (
    .i_size  (req_memSize),
    .i_off   (req_addr[1:0]),
    .i_wdata (req_wdata),
    .o_we    (w_lane_we),
    .o_wdata (mem_wdata)
  );

  // BRAM is driven straight from the request; there is no request buffer
  assign mem_en   = w_ld_go | w_st_go;
  assign mem_we   = w_st_go ? w_lane_we : 4'b0000;
  assign mem_addr = req_addr[ADDR_W+1:2];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_ld_go) w_state_nxt = ST_WAIT;
      ST_WAIT: if (flush || r_cnt == 2'd1) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 2'd0;
      r_rsp_addr  <= 32'd0;
      r_rsp_op    <= 2'd0;
      r_rsp_size  <= 2'd0;
      r_rsp_raw   <= 32'd0;
      r_rsp_valid <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_rsp_valid <= 1'b0;
      r_fault     <= w_accept & w_mis;
      if (r_state == ST_IDLE) begin
        if (w_ld_go) begin
          r_cnt      <= LP_LAT;
          r_rsp_addr <= req_addr;
          r_rsp_op   <= req_memOp;
          r_rsp_size <= req_memSize;
        end
      end else begin
        r_cnt <= r_cnt - 2'd1;
        // a flush landing on the final count still kills the response
        if (r_cnt == 2'd1 && !flush) begin
          r_rsp_raw   <= mem_rdata;
          r_rsp_valid <= 1'b1;
        end
      end
    end
  end

  assign rsp_addr       = r_rsp_addr;
  assign rsp_memOp      = r_rsp_op;
  assign rsp_memSize    = r_rsp_size;
  assign rsp_rawDin     = r_rsp_raw;
  assign rsp_readValid  = r_rsp_valid;
  assign misalign_fault = r_fault;

endmodule

// File: tb/tb_mem_request_unit.sv
// tb/tb_mem_request_unit.sv - self-checking bench for mem_request_unit at READ_LAT 1, 2 and 3
module tb_mem_request_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  op;
  logic [1:0]  sz;
  logic        flush;
  logic        valid_a   [3];
  logic        ready_a   [3];
  logic        mem_en_a  [3];
  logic [3:0]  we_a      [3];
  logic [11:0] maddr_a   [3];
  logic [31:0] mwdata_a  [3];
  logic [31:0] rdata_a   [3];
  logic [31:0] rsp_addr_a[3];
  logic [1:0]  rsp_op_a  [3];
  logic [1:0]  rsp_sz_a  [3];
  logic [31:0] raw_a     [3];
  logic        rv_a      [3];
  logic        fault_a   [3];

  logic [31:0] mem [64];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic [31:0] pipe [g+1];

    mem_request_unit #(.ADDR_W(12), .READ_LAT(g + 1)) u_dut (
      .clk            (clk),
      .rst            (rst),
      .req_valid      (valid_a[g]),
      .req_ready      (ready_a[g]),
      .req_addr       (addr),
      .req_wdata      (wdata),
      .req_memOp      (op),
      .req_memSize    (sz),
      .flush          (flush),
      .mem_en         (mem_en_a[g]),
      .mem_we         (we_a[g]),
      .mem_addr       (maddr_a[g]),
      .mem_wdata      (mwdata_a[g]),
      .mem_rdata      (rdata_a[g]),
      .rsp_addr       (rsp_addr_a[g]),
      .rsp_memOp      (rsp_op_a[g]),
      .rsp_memSize    (rsp_sz_a[g]),
      .rsp_rawDin     (raw_a[g]),
      .rsp_readValid  (rv_a[g]),
      .misalign_fault (fault_a[g])
    );

    // BRAM with g+1 cycles of read latency; junk on non-enabled cycles exposes timing slips
    always @(posedge clk) begin
      pipe[0] <= mem_en_a[g] ? mem[maddr_a[g][5:0]] : 32'h5A5A_5A5A;
      for (int k = 1; k <= g; k++) pipe[k] <= pipe[k-1];
    end
    assign rdata_a[g] = pipe[g];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    for (int g = 0; g < 3; g++) valid_a[g] = 1'b0;
    addr = 32'd0; wdata = 32'd0; op = 2'b00; sz = 2'b00; flush = 1'b0;
  endtask

  task automatic drive_req(input int sel, input logic [1:0] o, input logic [1:0] s,
                           input logic [31:0] a, input logic [31:0] d);
    valid_a[sel] = 1'b1; op = o; sz = s; addr = a; wdata = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    step();
    step();
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      checks++; if (ready_a[g] !== 1'b0) begin errors++; $display("FAIL reset_ready[%0d] got %b exp 0", g, ready_a[g]); end
      checks++; if (mem_en_a[g] !== 1'b0 || we_a[g] !== 4'b0) begin errors++; $display("FAIL reset_mem[%0d] got en=%b we=%b exp 0", g, mem_en_a[g], we_a[g]); end
      checks++; if (rv_a[g] !== 1'b0 || fault_a[g] !== 1'b0) begin errors++; $display("FAIL reset_pulse[%0d] got rv=%b flt=%b exp 0", g, rv_a[g], fault_a[g]); end
      checks++; if ({rsp_addr_a[g], rsp_op_a[g], rsp_sz_a[g], raw_a[g]} !== 68'd0) begin errors++; $display("FAIL reset_rsp[%0d] got %h exp 0", g, {rsp_addr_a[g], rsp_op_a[g], rsp_sz_a[g], raw_a[g]}); end
    end
    step();
    rst = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      checks++; if (ready_a[g] !== 1'b1) begin errors++; $display("FAIL post_reset_ready[%0d] got %b exp 1", g, ready_a[g]); end
    end
    step();
  endtask

  task automatic test_store_byte();
    drive_req(0, 2'b11, 2'b00, 32'h0000_0103, 32'h0000_00AB);
    @(negedge clk);
    checks++; if (mem_en_a[0] !== 1'b1) begin errors++; $display("FAIL stb_en got %b exp 1", mem_en_a[0]); end
    checks++; if (we_a[0] !== 4'b1000) begin errors++; $display("FAIL stb_we got %b exp 1000", we_a[0]); end
    checks++; if (mwdata_a[0] !== 32'hABAB_ABAB) begin errors++; $display("FAIL stb_wdata got %h exp ababab ab", mwdata_a[0]); end
    checks++; if (maddr_a[0] !== 12'h040) begin errors++; $display("FAIL stb_addr got %h exp 040", maddr_a[0]); end
    step();
    drive_idle();
    @(negedge clk);
    checks++; if (rv_a[0] !== 1'b0 || fault_a[0] !== 1'b0) begin errors++; $display("FAIL stb_no_pulse got rv=%b flt=%b exp 0", rv_a[0], fault_a[0]); end
    step();
  endtask

  task automatic test_load_word();
    mem[4] = 32'hDEAD_BEEF;
    drive_req(0, 2'b01, 2'b10, 32'h0000_0010, 32'd0);
    @(negedge clk);
    checks++; if (mem_en_a[0] !== 1'b1 || we_a[0] !== 4'b0) begin errors++; $display("FAIL ldw_mem got en=%b we=%b exp 1/0000", mem_en_a[0], we_a[0]); end
    step();
    drive_idle();
    @(negedge clk);
    checks++; if (ready_a[0] !== 1'b0 || rv_a[0] !== 1'b0) begin errors++; $display("FAIL ldw_t1 got ready=%b rv=%b exp 0/0", ready_a[0], rv_a[0]); end
    step();
    @(negedge clk);
    checks++; if (rv_a[0] !== 1'b1) begin errors++; $display("FAIL ldw_valid got %b exp 1", rv_a[0]); end
    checks++; if (raw_a[0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ldw_raw got %h exp deadbeef", raw_a[0]); end
    checks++; if (rsp_addr_a[0] !== 32'h10 || rsp_op_a[0] !== 2'b01 || rsp_sz_a[0] !== 2'b10) begin errors++; $display("FAIL ldw_ctx got %h/%b/%b exp 10/01/10", rsp_addr_a[0], rsp_op_a[0], rsp_sz_a[0]); end
    checks++; if (ready_a[0] !== 1'b1) begin errors++; $display("FAIL ldw_ready got %b exp 1", ready_a[0]); end
    step();
    @(negedge clk);
    checks++; if (rv_a[0] !== 1'b0) begin errors++; $display("FAIL ldw_pulse_width got %b exp 0", rv_a[0]); end
    step();
  endtask

  task automatic test_misalign();
    drive_req(0, 2'b11, 2'b01, 32'h0000_0001, 32'h1234_5678);
    @(negedge clk);
    checks++; if (mem_en_a[0] !== 1'b0 || we_a[0] !== 4'b0) begin errors++; $display("FAIL mis_en got en=%b we=%b exp 0", mem_en_a[0], we_a[0]); end
    step();
    drive_idle();
    @(negedge clk);
    checks++; if (fault_a[0] !== 1'b1) begin errors++; $display("FAIL mis_fault got %b exp 1", fault_a[0]); end
    checks++; if (ready_a[0] !== 1'b1) begin errors++; $display("FAIL mis_ready got %b exp 1", ready_a[0]); end
    step();
    @(negedge clk);
    checks++; if (fault_a[0] !== 1'b0) begin errors++; $display("FAIL mis_fault_width got %b exp 0", fault_a[0]); end
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] a1, a2;
    a1 = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
    a2 = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
    drive_req(2, 2'b10, 2'b10, a1, 32'd0);
    for (int k = 0; k <= 9; k++) begin
      @(negedge clk);
      checks++; if (mem_en_a[2] !== (k == 0 || k == 4)) begin errors++; $display("FAIL b2b_en t+%0d got %b exp %b", k, mem_en_a[2], (k == 0 || k == 4)); end
      checks++; if (rv_a[2] !== (k == 4 || k == 8)) begin errors++; $display("FAIL b2b_rv t+%0d got %b exp %b", k, rv_a[2], (k == 4 || k == 8)); end
      if (k == 4) begin
        checks++; if (raw_a[2] !== mem[a1[7:2]] || rsp_addr_a[2] !== a1) begin errors++; $display("FAIL b2b_rsp1 got %h@%h exp %h@%h", raw_a[2], rsp_addr_a[2], mem[a1[7:2]], a1); end
      end
      if (k == 8) begin
        checks++; if (raw_a[2] !== mem[a2[7:2]] || rsp_addr_a[2] !== a2) begin errors++; $display("FAIL b2b_rsp2 got %h@%h exp %h@%h", raw_a[2], rsp_addr_a[2], mem[a2[7:2]], a2); end
      end
      step();
      if (k == 0) drive_req(2, 2'b10, 2'b10, a2, 32'd0);
      if (k == 4) drive_idle();
    end
  endtask

  task automatic test_flush();
    drive_req(1, 2'b01, 2'b10, 32'h0000_0040, 32'd0);
    step();
    drive_idle();
    flush = 1'b1;
    @(negedge clk);
    checks++; if (ready_a[1] !== 1'b0) begin errors++; $display("FAIL fl_busy got %b exp 0", ready_a[1]); end
    step();
    flush = 1'b0;
    drive_req(1, 2'b01, 2'b10, 32'h0000_0020, 32'd0);
    @(negedge clk);
    checks++; if (ready_a[1] !== 1'b1 || mem_en_a[1] !== 1'b1) begin errors++; $display("FAIL fl_reaccept got ready=%b en=%b exp 1/1", ready_a[1], mem_en_a[1]); end
    step();
    drive_idle();
    for (int k = 3; k <= 6; k++) begin
      @(negedge clk);
      checks++; if (rv_a[1] !== (k == 5)) begin errors++; $display("FAIL fl_rv t+%0d got %b exp %b", k, rv_a[1], (k == 5)); end
      if (k == 5) begin
        checks++; if (raw_a[1] !== mem[8]) begin errors++; $display("FAIL fl_raw got %h exp %h", raw_a[1], mem[8]); end
      end
      step();
    end
    // flush on the last wait cycle
    drive_req(1, 2'b10, 2'b00, 32'h0000_0033, 32'd0);
    step();
    drive_idle();
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int k = 3; k <= 4; k++) begin
      @(negedge clk);
      checks++; if (rv_a[1] !== 1'b0 || ready_a[1] !== 1'b1) begin errors++; $display("FAIL fl_last t+%0d got rv=%b ready=%b exp 0/1", k, rv_a[1], ready_a[1]); end
      step();
    end
  endtask

  task automatic test_reset_mid_wait();
    drive_req(2, 2'b10, 2'b10, 32'h0000_0030, 32'd0);
    step();
    drive_idle();
    rst = 1'b1;
    @(negedge clk);
    checks++; if (ready_a[2] !== 1'b0) begin errors++; $display("FAIL rmw_ready got %b exp 0", ready_a[2]); end
    step();
    @(negedge clk);
    checks++; if ({rsp_addr_a[2], rsp_op_a[2], rsp_sz_a[2], raw_a[2], rv_a[2], fault_a[2], mem_en_a[2]} !== 71'd0) begin errors++; $display("FAIL rmw_outputs got addr=%h op=%b rv=%b exp 0", rsp_addr_a[2], rsp_op_a[2], rv_a[2]); end
    step();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++; if (rv_a[2] !== 1'b0 || ready_a[2] !== 1'b1) begin errors++; $display("FAIL rmw_after %0d got rv=%b ready=%b exp 0/1", k, rv_a[2], ready_a[2]); end
      step();
    end
  endtask

  task automatic test_random(input int sel);
    int lat, busy_end, rv_cyc, flt_cyc, n;
    logic v, fl, mis, acc, e_en;
    logic [1:0] o, s, e_op, e_sz;
    logic [31:0] a, d, e_addr, e_raw, e_wd;
    logic [3:0] e_we;
    lat = sel + 1; busy_end = 0; rv_cyc = -1; flt_cyc = -1;
    e_op = 2'b00; e_sz = 2'b00; e_addr = 32'd0; e_raw = 32'd0;
    for (int c = 0; c < 120; c++) begin
      v  = ($urandom_range(0, 3) != 0);
      o  = 2'($urandom_range(0, 3));
      s  = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      a  = $urandom_range(0, 255);
      if ($urandom_range(0, 3) != 0 && s != 2'b11) a = a & ~((32'd1 << s) - 32'd1);
      d  = $urandom;
      fl = ($urandom_range(0, 9) == 0);
      valid_a[sel] = v; op = o; sz = s; addr = a; wdata = d; flush = fl;
      @(negedge clk);
      acc  = v && (c >= busy_end);
      mis  = (o != 2'b00) && (s == 2'b11 || (s == 2'b01 && a[0]) || (s == 2'b10 && a[1:0] != 2'b00));
      e_en = acc && (o != 2'b00) && !mis;
      checks++; if (ready_a[sel] !== (c >= busy_end)) begin errors++; $display("FAIL rnd%0d_ready c%0d got %b exp %b", sel, c, ready_a[sel], (c >= busy_end)); end
      checks++; if (mem_en_a[sel] !== e_en) begin errors++; $display("FAIL rnd%0d_en c%0d got %b exp %b", sel, c, mem_en_a[sel], e_en); end
      if (e_en) begin
        e_we = 4'b0; e_wd = 32'd0;
        if (o == 2'b11) begin
          n = 1 << s;
          for (int i = 0; i < 4; i++) begin
            if (i >= a[1:0] && i < a[1:0] + n) e_we[i] = 1'b1;
            e_wd[8*i +: 8] = d[8*(i % n) +: 8];
          end
          checks++; if (mwdata_a[sel] !== e_wd) begin errors++; $display("FAIL rnd%0d_wdata c%0d got %h exp %h", sel, c, mwdata_a[sel], e_wd); end
        end
        checks++; if (we_a[sel] !== e_we || maddr_a[sel] !== a[13:2]) begin errors++; $display("FAIL rnd%0d_we c%0d got %b@%h exp %b@%h", sel, c, we_a[sel], maddr_a[sel], e_we, a[13:2]); end
      end
      checks++; if (rv_a[sel] !== (c == rv_cyc)) begin errors++; $display("FAIL rnd%0d_rv c%0d got %b exp %b", sel, c, rv_a[sel], (c == rv_cyc)); end
      if (c == rv_cyc) begin
        checks++; if (raw_a[sel] !== e_raw || rsp_addr_a[sel] !== e_addr || rsp_op_a[sel] !== e_op || rsp_sz_a[sel] !== e_sz) begin
          errors++; $display("FAIL rnd%0d_rsp c%0d got %h@%h/%b/%b exp %h@%h/%b/%b", sel, c, raw_a[sel], rsp_addr_a[sel], rsp_op_a[sel], rsp_sz_a[sel], e_raw, e_addr, e_op, e_sz);
        end
      end
      checks++; if (fault_a[sel] !== (c == flt_cyc)) begin errors++; $display("FAIL rnd%0d_fault c%0d got %b exp %b", sel, c, fault_a[sel], (c == flt_cyc)); end
      if (fl && c < busy_end) begin
        busy_end = c + 1;
        rv_cyc = -1;
      end
      if (acc && mis) flt_cyc = c + 1;
      if (e_en && o != 2'b11) begin
        busy_end = c + lat + 1;
        rv_cyc = c + lat + 1;
        e_addr = a; e_op = o; e_sz = s; e_raw = mem[a[7:2]];
      end
      step();
    end
    drive_idle();
    repeat (6) step();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    test_reset();
    test_store_byte();
    test_load_word();
    test_misalign();
    test_back_to_back();
    test_flush();
    test_reset_mid_wait();
    for (int s = 0; s < 3; s++) test_random(s);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_request_unit.md
Name: mem_request_unit

Overview:
- Sits between the execute stage and data BRAM, directly upstream of the load output stage (memOutputLogic_).
- Accepts one memory request per handshake and checks alignment.
- Stores: generates byte enables and lane-replicated write data.
- Loads: tracks the read latency and presents raw read data plus request context to the output stage with a one-cycle readValid pulse.

Parameters:
- ADDR_W, 12: word-address width driven to the BRAM.
- READ_LAT, 1: BRAM read latency in cycles (legal 1..3).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request present from execute
- req_ready  out  1  unit can accept a request this cycle
- req_addr  in  32  byte address
- req_wdata  in  32  store data (low bits significant)
- req_memOp  in  2  00 none, 01 load signed, 10 load unsigned, 11 store
- req_memSize  in  2  00 byte, 01 half, 10 word, 11 illegal
- flush  in  1  cancel any pending load response
- mem_en  out  1  BRAM enable
- mem_we  out  4  BRAM byte write enables
- mem_addr  out  ADDR_W  word address = req_addr[ADDR_W+1:2]
- mem_wdata  out  32  lane-replicated store data
- mem_rdata  in  32  BRAM read data, valid READ_LAT cycles after the enable edge
- rsp_addr  out  32  captured address of the returned load
- rsp_memOp  out  2  captured memOp
- rsp_memSize  out  2  captured memSize
- rsp_rawDin  out  32  captured mem_rdata
- rsp_readValid  out  1  one-cycle pulse: load data valid
- misalign_fault  out  1  one-cycle pulse: rejected access

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset:
  - State goes to IDLE and the latency counter to 0.
  - All rsp_* outputs are 0; misalign_fault is 0.
  - mem_en and mem_we are 0.
  - req_ready is 0 while rst is high and 1 in the first cycle after.
- Handshake: a request is accepted in cycle T when req_valid and req_ready are both 1. The unit holds no request buffer; mem_* are combinational from req_* in the accept cycle only.
- FSM states: IDLE, WAIT.
- IDLE: req_ready=1.
  - memOp 00: accepted, no BRAM access, no response.
  - Misaligned request: half with addr[0]=1, word with addr[1:0]!=0, or memSize 11. Accepted, no BRAM access (mem_en=0). misalign_fault=1 in cycle T+1. State stays IDLE.
  - Store: mem_en=1, mem_we set from size and addr[1:0]:
    - byte: 1<<addr[1:0]
    - half: 0011 or 1100
    - word: 1111
  - Store write data: byte is {4{wdata[7:0]}}, half is {2{wdata[15:0]}}, word is unchanged. State stays IDLE; no rsp_readValid.
  - Load (01/10): mem_en=1, mem_we=0. Capture addr, memOp and memSize; load the counter with READ_LAT; go to WAIT.
- WAIT:
  - req_ready=0; mem_en=0.
  - The counter decrements each cycle. When it reaches 1, capture mem_rdata into rsp_rawDin and assert rsp_readValid in the next cycle, cycle T+READ_LAT+1. Return to IDLE.
  - req_ready=1 in the response cycle, so back-to-back loads sustain one load every READ_LAT+1 cycles.
- rsp_addr, rsp_memOp and rsp_memSize hold their last captured value until the next load capture.
- flush:
  - In WAIT: return to IDLE next cycle with no rsp_readValid. The in-flight BRAM read is ignored.
  - In IDLE: the current cycle's request is still accepted. flush has no effect on stores.
  - flush in the same cycle the counter reaches 1: the response is suppressed.
- rst mid-WAIT: the pending response is dropped; no pulse is ever emitted for it.
- At most one of rsp_readValid or misalign_fault is high in any cycle.

Decomposition:
- Package mem_pkg holds:
  - memOp encodings: MEMOP_NONE, MEMOP_LDS, MEMOP_LDU, MEMOP_ST.
  - memSize encodings: SZ_B, SZ_H, SZ_W.
  - Functions byte_en(size, off) and is_misaligned(size, off).
- One combinational sub-module, store_lane_gen, produces mem_we and mem_wdata from size, offset and wdata. FSM, counter and capture registers stay in the top level.

Test Plan:
- Store byte, addr 0x0000_0103, wdata 0x0000_00AB -> cycle T: mem_en=1, mem_we=1000, mem_wdata=0xABABABAB, mem_addr=0x040; no rsp_readValid.
- Load word, addr 0x0000_0010, READ_LAT=1, BRAM word 4 = 0xDEADBEEF -> req_ready=0 at T+1; at T+2: rsp_readValid=1, rsp_rawDin=0xDEADBEEF, rsp_addr=0x10, rsp_memOp=01.
- Half store at 0x0000_0001 -> mem_en=0 at T, misalign_fault=1 at T+1, req_ready stays 1.
- READ_LAT=3, two back-to-back unsigned loads -> exactly two rsp_readValid pulses, at T+4 and T+8, each with the correct data and address.
- Load accepted, flush at T+1, READ_LAT=2 -> no rsp_readValid; req_ready=1 at T+2; a new request at T+2 is accepted.
- rst asserted at T+1 of a pending load -> all outputs 0 during reset; no response pulse afterwards.
